inv_sub_bytes_iter: RTL and testbench

Iterative InvSubBytes engine for the AES decryption datapath. It applies the inverse S-box to all 16 bytes of a 128-bit state, BYTES_PER_CYCLE bytes per clock, so only BYTES_PER_CYCLE lookup tables are needed. It sits between InvShiftRows and AddRoundKey in the inverse round. It uses valid/ready handshakes on both the input and output sides.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/inv_sub_bytes_iter_if.sv | 24 ++
 rtl/inv_sub_bytes_iter_inv_sbox.sv | 21 ++
 rtl/inv_sub_bytes_iter.sv | 122 ++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and lookup tables for the inverse-round datapath.
// The forward table exists only when INV_SUB_BYTES_SELFCHECK_EN is defined.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 32'd16;

    typedef logic [7:0] byte_t;
    typedef logic [8*AES_BLOCK_BYTES-1:0] blk_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} fsm_state_t;

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
`endif

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// Valid/ready bundle for the iterative InvSubBytes engine: input state in,
// substituted state out, plus the busy indication.
interface inv_sub_bytes_iter_if;
    import aes_pkg::*;

    logic  in_valid;
    logic  in_ready;
    blk_t  in_state;
    logic  out_valid;
    logic  out_ready;
    blk_t  out_state;
    logic  busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// Single-byte combinational S-box lookups. The forward lookup (sbox) is only
// built when INV_SUB_BYTES_SELFCHECK_EN is defined.
module inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);
    assign out_byte = INV_SBOX[in_byte];
endmodule

`ifdef INV_SUB_BYTES_SELFCHECK_EN
module sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);
    assign out_byte = SBOX[in_byte];
endmodule
`endif

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the held state
// per clock, lowest bytes first. INV_SUB_BYTES_SELFCHECK_EN adds sticky chk_err.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_sub_bytes_iter_if.slave   bus
`ifdef INV_SUB_BYTES_SELFCHECK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int NUM_CHUNKS = int'(AES_BLOCK_BYTES) / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int CHUNK_W    = 8 * BYTES_PER_CYCLE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    fsm_state_t           state_r;
    logic [CNT_W-1:0]     cnt_r;
    blk_t                 work_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [CHUNK_W-1:0]   chunk_s;
    logic [CHUNK_W-1:0]   sub_s;

    // Select the chunk currently being substituted.
    always_comb begin
        chunk_s = work_r[int'(cnt_r) * CHUNK_W +: CHUNK_W];
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lut
        inv_sbox u_inv_sbox (
            .in_byte  (chunk_s[8*g +: 8]),
            .out_byte (sub_s[8*g +: 8])
        );
    end

    // Control FSM, working register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            work_r      <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_r     <= bus.in_state;
                        cnt_r      <= '0;
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    work_r[int'(cnt_r) * CHUNK_W +: CHUNK_W] <= sub_s;
                    // Counter parks on the last chunk so it never wraps.
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.out_state = work_r;

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [CHUNK_W-1:0] fwd_s;
    logic               chk_err_r;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_fwd
        sbox u_sbox (
            .in_byte  (sub_s[8*g +: 8]),
            .out_byte (fwd_s[8*g +: 8])
        );
    end

    // Sticky flag: a round trip through the forward table must restore the byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_err_r <= 1'b0;
        end else if ((state_r == RUN) && (fwd_s != chunk_s)) begin
            chk_err_r <= 1'b1;
        end else begin
            chk_err_r <= chk_err_r;
        end
    end

    assign chk_err = chk_err_r;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Randomized self-checking bench for inv_sub_bytes_iter against a GF(2^8)
// derived inverse S-box; INV_SUB_BYTES_SELFCHECK_EN also checks chk_err.
module tb_inv_sub_bytes_iter;
    import aes_pkg::*;

    localparam int MAIN_BPC = 4;
    localparam int MAIN_LAT = 16 / MAIN_BPC;
    localparam blk_t KNOWN_IN  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam blk_t KNOWN_EXP = 128'h0f0e0d0c0b0a09080706050403020100;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    logic [7:0] ref_inv [256];

    inv_sub_bytes_iter_if bus ();

    logic        sw_in_valid;
    blk_t        sw_in_state;
    logic        sw_out_ready;
    logic [3:0]  sw_out_valid;
    blk_t        sw_out_state [4];

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic        chk_err;
    logic [3:0]  sw_chk_err;
`endif

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(MAIN_BPC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef INV_SUB_BYTES_SELFCHECK_EN
        ,
        .chk_err (chk_err)
`endif
    );

    for (genvar k = 0; k < 4; k++) begin : g_sweep
        localparam int SW_BPC = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 16;
        inv_sub_bytes_iter_if sw_bus ();
        assign sw_bus.in_valid  = sw_in_valid;
        assign sw_bus.in_state  = sw_in_state;
        assign sw_bus.out_ready = sw_out_ready;
        assign sw_out_valid[k]  = sw_bus.out_valid;
        assign sw_out_state[k]  = sw_bus.out_state;
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(SW_BPC)) u_sw (
            .clk     (clk),
            .rst_n   (rst_n),
            .bus     (sw_bus)
`ifdef INV_SUB_BYTES_SELFCHECK_EN
            ,
            .chk_err (sw_chk_err[k])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from field inverse + affine map, then inverted by table.
    task automatic build_ref();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic blk_t model(input blk_t blk);
        blk_t r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_inv[blk[8*i +: 8]];
        return r;
    endfunction

    function automatic blk_t rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input string tag, input blk_t blk, input blk_t exp, input int hold);
        int lat;
        check_val({tag, "/idle_in_ready"}, bus.in_ready, 1'b1);
        bus.in_state  = blk;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.in_state = rand_blk();
        check_val({tag, "/run_busy"}, bus.busy, 1'b1);
        check_val({tag, "/run_in_ready"}, bus.in_ready, 1'b0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check_val({tag, "/latency"}, lat, MAIN_LAT);
        check_val({tag, "/result"}, bus.out_state, exp);
        bus.in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            check_val({tag, "/hold_valid"}, bus.out_valid, 1'b1);
            check_val({tag, "/hold_state"}, bus.out_state, exp);
            check_val({tag, "/hold_in_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val({tag, "/post_valid"}, bus.out_valid, 1'b0);
        check_val({tag, "/post_in_ready"}, bus.in_ready, 1'b1);
        check_val({tag, "/post_busy"}, bus.busy, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        int   sw_lat [4];
        blk_t sw_res [4];
        blk_t blk;
        n_chk  = 0;
        n_pass = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;
        sw_in_valid   = 1'b0;
        sw_in_state   = '0;
        sw_out_ready  = 1'b1;
        build_ref();

        tick();
        tick();
        rst_n = 1'b1;
        check_val("rst/in_ready", bus.in_ready, 1'b1);
        check_val("rst/out_valid", bus.out_valid, 1'b0);
        check_val("rst/busy", bus.busy, 1'b0);
        check_val("rst/out_state", bus.out_state, '0);

        run_block("known", KNOWN_IN, KNOWN_EXP, 0);
        run_block("zeros", {16{8'h00}}, {16{8'h52}}, 1);
        run_block("x16", {16{8'h16}}, {16{8'hff}}, 0);
        run_block("xed", {16{8'hed}}, {16{8'h53}}, 2);
        run_block("bp", KNOWN_IN, KNOWN_EXP, 10);

        // Reset after two RUN edges must drop the block.
        bus.in_state = rand_blk();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midrst/out_valid", bus.out_valid, 1'b0);
        check_val("midrst/in_ready", bus.in_ready, 1'b1);
        check_val("midrst/out_state", bus.out_state, '0);
        check_val("midrst/busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        run_block("after_rst", {16{8'h63}}, {16{8'h00}}, 0);

        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * j + i);
            run_block("allbytes", blk, model(blk), 0);
        end

        for (int n = 0; n < 20; n++) begin
            blk = rand_blk();
            run_block("rand", blk, model(blk), int'($urandom_range(0, 3)));
        end

        sw_in_state = KNOWN_IN;
        sw_in_valid = 1'b1;
        tick();
        sw_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sw_lat[k] = 0;
            sw_res[k] = '0;
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (sw_out_valid[k] && sw_lat[k] == 0) begin
                    sw_lat[k] = t;
                    sw_res[k] = sw_out_state[k];
                end
            end
        end
        check_val("sweep1/lat", sw_lat[0], 16);
        check_val("sweep2/lat", sw_lat[1], 8);
        check_val("sweep8/lat", sw_lat[2], 2);
        check_val("sweep16/lat", sw_lat[3], 1);
        for (int k = 0; k < 4; k++) check_val("sweep/result", sw_res[k], KNOWN_EXP);

        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * j + i);
            sw_in_state = blk;
            sw_in_valid = 1'b1;
            tick();
            sw_in_valid = 1'b0;
            for (int t = 0; t < 18; t++) tick();
        end
`ifdef INV_SUB_BYTES_SELFCHECK_EN
        check_val("chk_err/main", chk_err, 1'b0);
        check_val("chk_err/sweep", sw_chk_err, 4'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
